modport_ram: RTL and testbench

- Simple dual-port synchronous RAM: 16 words x 8 bits, one write port and one read port, both on a single clock.
- Write and read ports are independent and may be active in the same cycle.
- Sits behind the write-driver/monitor and read-driver/monitor agents as the storage block under verification.

---
 rtl/ram_pkg.sv | 21 ++
 rtl/ram_mem_array.sv | 44 ++++
 rtl/modport_ram.sv | 75 +++++++
 tb/tb_modport_ram.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram_pkg
//  Description : Shared sizing constants and word/address types for the
//                modport_ram storage block.
//                  ADDR_W : address width (4)
//                  DATA_W : data word width (8)
//                  DEPTH  : number of words, 2**ADDR_W (16)
//  Revision    : 1.0 - initial release
// ============================================================================
package ram_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

endpackage : ram_pkg
`default_nettype wire

// File: rtl/ram_mem_array.sv
`default_nettype none
// ============================================================================
//  Module      : ram_mem_array
//  Description : DEPTH x DATA_W storage array with asynchronous clear, one
//                synchronous write port and a combinational read of any word.
//  Ports       : clk      - system clock (writes on posedge)
//                rst      - asynchronous active-high clear of every word
//                wr_enb   - write enable
//                wr_addr  - write address
//                wr_data  - write data
//                rd_addr  - combinational read address
//                rd_word  - contents of the addressed word
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_mem_array
    import ram_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_enb,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_word
);

    data_t r_mem [DEPTH];

    // Every word is cleared by reset, so the array lives in flops rather
    // than an inferred block RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (wr_enb) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_word = r_mem[rd_addr];

endmodule : ram_mem_array
`default_nettype wire

// File: rtl/modport_ram.sv
`default_nettype none
// ============================================================================
//  Module      : modport_ram
//  Description : 16 x 8 simple dual-port synchronous RAM, one write port and
//                one registered read port on a single clock. A read and a
//                write to the same address in one cycle return the new data
//                (write-first). rd_data holds when rd_enb is low.
//  Ports       : clk      - system clock
//                rst      - asynchronous active-high reset
//                wr_enb   - write enable
//                wr_addr  - write address
//                wr_data  - write data
//                rd_enb   - read enable
//                rd_addr  - read address
//                rd_data  - registered read data (1-cycle latency)
//  Options     : RAM_ACTIVITY_CHECK_EN - when defined, adds a per-cycle
//                wr/rd activity assertion and a same-address collision cover.
//  Revision    : 1.0 - initial release
// ============================================================================
module modport_ram
    import ram_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_enb,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_enb,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    data_t w_mem_word;
    data_t w_rd_next;
    logic  w_collision;
    data_t r_rd_data;

    ram_mem_array u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_enb  (wr_enb),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_word (w_mem_word)
    );

    // The array only sees the write at the same edge the read is sampled,
    // so a same-address collision is served straight from wr_data.
    assign w_collision = wr_enb && rd_enb && (wr_addr == rd_addr);
    assign w_rd_next   = w_collision ? wr_data : w_mem_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (rd_enb) begin
            r_rd_data <= w_rd_next;
        end
    end

    assign rd_data = r_rd_data;

`ifdef RAM_ACTIVITY_CHECK_EN
    a_activity : assert property (@(posedge clk) disable iff (rst)
                                  (wr_enb || rd_enb))
        $info("wr/rd activity assertion passed");
    else
        $info("wr/rd activity assertion failed");

    c_collision : cover property (@(posedge clk) disable iff (rst)
                                  w_collision);
`endif

endmodule : modport_ram
`default_nettype wire

// File: tb/tb_modport_ram.sv
`default_nettype none
// ============================================================================
//  Module      : tb_modport_ram
//  Description : Self-checking bench for modport_ram. Expected read data is
//                pushed to a scoreboard queue when a read is driven and
//                popped after the sampling edge; a reference memory model
//                produces the expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_modport_ram;

    localparam int c_aw    = 4;
    localparam int c_dw    = 8;
    localparam int c_depth = 16;

    logic            clk;
    logic            rst;
    logic            wr_enb;
    logic [c_aw-1:0] wr_addr;
    logic [c_dw-1:0] wr_data;
    logic            rd_enb;
    logic [c_aw-1:0] rd_addr;
    logic [c_dw-1:0] rd_data;

    int n_tests = 0;
    int n_fail  = 0;

    logic [c_dw-1:0] model_mem [c_depth];
    logic [c_dw-1:0] exp_q [$];
    logic [c_dw-1:0] exp_hold;

    modport_ram dut (
        .clk     (clk),
        .rst     (rst),
        .wr_enb  (wr_enb),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_enb  (rd_enb),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [c_dw-1:0] got,
                             input logic [c_dw-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h required 0x%h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < c_depth; i++) model_mem[i] = '0;
        exp_hold = '0;
        exp_q.delete();
    endtask

    // One clock cycle of stimulus, driven just after an edge; any read is
    // scored right after the next posedge.
    task automatic do_cycle(input string tag,
                            input logic we, input logic [c_aw-1:0] wa,
                            input logic [c_dw-1:0] wd,
                            input logic re, input logic [c_aw-1:0] ra);
        logic [c_dw-1:0] exp;
        wr_enb  = we;
        wr_addr = wa;
        wr_data = wd;
        rd_enb  = re;
        rd_addr = ra;
        if (re) begin
            exp = (we && wa == ra) ? wd : model_mem[ra];
            exp_q.push_back(exp);
            exp_hold = exp;
        end
        if (we) model_mem[wa] = wd;
        @(posedge clk);
        #1;
        if (re) begin
            if (exp_q.size() == 0) begin
                check_val({tag, "_sb_empty"}, rd_data, ~rd_data);
            end else begin
                check_val(tag, rd_data, exp_q.pop_front());
            end
        end else begin
            check_val({tag, "_hold"}, rd_data, exp_hold);
        end
    endtask

    task automatic idle_inputs();
        wr_enb  = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rd_enb  = 1'b0;
        rd_addr = '0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        model_clear();
        #2;
        check_val("rst_init", rd_data, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        // Random prior contents, then make rd_data non-zero before reset.
        for (int i = 0; i < c_depth; i++) begin
            do_cycle("pre_wr", 1'b1, c_aw'(i), 8'($urandom_range(0, 255)), 1'b0, '0);
        end
        do_cycle("pre_wr0", 1'b1, 4'd0, 8'h5A, 1'b0, '0);
        do_cycle("pre_rd0", 1'b0, '0, '0, 1'b1, 4'd0);

        // Reset held for two cycles while the ports try to write and read.
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("rst_async", rd_data, 8'h00);
        for (int c = 0; c < 2; c++) begin
            wr_enb  = 1'b1;
            wr_addr = c_aw'(c);
            wr_data = 8'hEE;
            rd_enb  = 1'b1;
            rd_addr = c_aw'(c);
            @(posedge clk);
            #1;
            check_val("rst_hold", rd_data, 8'h00);
        end
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        model_clear();
        for (int i = 0; i < c_depth; i++) begin
            do_cycle("rst_sweep", 1'b0, '0, '0, 1'b1, c_aw'(i));
        end

        // Basic write then read.
        do_cycle("basic_wr", 1'b1, 4'd3, 8'hA5, 1'b0, '0);
        do_cycle("basic_rd", 1'b0, '0, '0, 1'b1, 4'd3);

        // Full sweep.
        for (int i = 0; i < c_depth; i++) begin
            do_cycle("sweep_wr", 1'b1, c_aw'(i), 8'(8'h10 + i), 1'b0, '0);
        end
        for (int i = 0; i < c_depth; i++) begin
            do_cycle("sweep_rd", 1'b0, '0, '0, 1'b1, c_aw'(i));
        end

        // Same-address collision is write-first.
        do_cycle("coll_pre", 1'b1, 4'd7, 8'h11, 1'b0, '0);
        do_cycle("coll", 1'b1, 4'd7, 8'h3C, 1'b1, 4'd7);
        do_cycle("coll_idle", 1'b0, '0, '0, 1'b0, 4'd0);
        do_cycle("coll_after", 1'b0, '0, '0, 1'b1, 4'd7);

        // Different-address simultaneous access.
        do_cycle("diff", 1'b1, 4'd2, 8'h77, 1'b1, 4'd4);
        do_cycle("diff_rd", 1'b0, '0, '0, 1'b1, 4'd2);

        // Hold with rd_enb low.
        do_cycle("hold_wr", 1'b1, 4'd3, 8'hA5, 1'b0, '0);
        do_cycle("hold_rd", 1'b0, '0, '0, 1'b1, 4'd3);
        for (int c = 0; c < 3; c++) begin
            do_cycle("hold", 1'b0, '0, '0, 1'b0, 4'd9);
        end

        // Reset between edges with a write in flight.
        @(negedge clk);
        wr_enb  = 1'b1;
        wr_addr = 4'd5;
        wr_data = 8'hFF;
        rd_enb  = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_val("mid_rst_async", rd_data, 8'h00);
        @(posedge clk);
        #1;
        check_val("mid_rst_hold", rd_data, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        model_clear();
        do_cycle("mid_rst_rd5", 1'b0, '0, '0, 1'b1, 4'd5);
        do_cycle("mid_rst_rd3", 1'b0, '0, '0, 1'b1, 4'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_modport_ram
`default_nettype wire
